data_memory: RTL and testbench

- Word-addressed, single-port data memory for the SPARC datapath, used by the memory stage for load/store.
- Synchronous write on the rising clock edge; combinational (asynchronous) read.
- Synchronous active-high reset clears the whole array to zero.

---
 rtl/data_memory_pkg.sv | 20 ++
 rtl/data_memory_if.sv | 34 +++
 rtl/data_memory.sv | 43 ++++
 tb/tb_data_memory.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_memory_pkg                                                 |
// | Brief    : Default geometry for the word-addressed data memory.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package data_memory_pkg;

    localparam int unsigned c_DATA_WIDTH = 32;
    localparam int unsigned c_ADDR_WIDTH = 32;
    localparam int unsigned c_DEPTH      = 256;

    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned c_IDX_WIDTH = idx_width(c_DEPTH);

endpackage : data_memory_pkg
`default_nettype wire

// File: rtl/data_memory_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_memory_if                                                  |
// | Brief    : Load/store bus between the memory stage and the data memory.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface data_memory_if
    import data_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = c_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  memwrite;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output addr,
        output write_data,
        output memwrite,
        input  read_data
    );

    modport slave (
        input  addr,
        input  write_data,
        input  memwrite,
        output read_data
    );

endinterface : data_memory_if
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_memory                                                     |
// | Brief    : Single-port word-addressed RAM, sync write, async read.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int unsigned DEPTH      = c_DEPTH
)
(
    input  wire logic         clk,
    input  wire logic         rst,
    data_memory_if.slave      bus
);

    localparam int unsigned c_IDX_W = idx_width(DEPTH);

    // Two-state storage so reads are 0, never X, before the first reset.
    bit   [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_in_range;
    logic [c_IDX_W-1:0]    w_idx;

    // DEPTH is a power of two, so "addr < DEPTH" means no bits above the index.
    assign w_in_range = ((bus.addr >> c_IDX_W) == '0);
    assign w_idx      = bus.addr[c_IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (bus.memwrite && w_in_range) begin
            r_mem[w_idx] <= bus.write_data;
        end
    end

    assign bus.read_data = w_in_range ? DATA_WIDTH'(r_mem[w_idx]) : '0;

endmodule : data_memory
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_data_memory                                                  |
// | Brief    : Scoreboard bench for data_memory against an array model.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_data_memory;

    localparam int unsigned c_DW    = 32;
    localparam int unsigned c_AW    = 40;
    localparam int unsigned c_DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    data_memory_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) bus ();

    data_memory #(
        .DATA_WIDTH (c_DW),
        .ADDR_WIDTH (c_AW),
        .DEPTH      (c_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [c_DW-1:0] model [c_DEPTH];
    logic [c_DW-1:0] exp_q  [$];
    string           name_q [$];
    event            sample_ev;
    int              vectors     = 0;
    int              miscompares = 0;

    function automatic logic [c_DW-1:0] exp_read(input logic [c_AW-1:0] a);
        if (a < c_AW'(c_DEPTH)) return model[a[7:0]];
        return '0;
    endfunction

    // Advance one rising edge and apply the memory rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < int'(c_DEPTH); i++) model[i] = '0;
        end else if (bus.memwrite && bus.addr < c_AW'(c_DEPTH)) begin
            model[bus.addr[7:0]] = bus.write_data;
        end
        #1;
    endtask

    task automatic check(input string name);
        exp_q.push_back(exp_read(bus.addr));
        name_q.push_back(name);
        -> sample_ev;
        #1;
    endtask

    task automatic drive(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d, input logic we);
        bus.addr       = a;
        bus.write_data = d;
        bus.memwrite   = we;
    endtask

    initial begin : monitor
        logic [c_DW-1:0] e;
        string           n;
        forever begin
            @(sample_ev);
            e = exp_q.pop_front();
            n = name_q.pop_front();
            vectors++;
            if (bus.read_data !== e) begin
                miscompares++;
                $display("FAIL %s: addr=%h read_data=%h expected=%h",
                         n, bus.addr, bus.read_data, e);
            end
        end
    end

    initial begin : stimulus
        logic [c_AW-1:0] a;
        for (int i = 0; i < int'(c_DEPTH); i++) model[i] = '0;
        drive('0, '0, 1'b0);
        #2;
        check("power_up_word0");

        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(40'd1, '0, 1'b0);
        check("reset_word1");
        for (int i = 0; i < int'(c_DEPTH); i++) begin
            bus.addr = c_AW'(i);
            check("reset_sweep");
        end

        drive(40'd1, 32'd7, 1'b1);
        check("pre_edge_no_bypass");
        tick();
        check("post_edge_word1");
        bus.memwrite = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            check("idle_hold_word1");
        end

        drive(40'd5, 32'd3, 1'b1);
        tick();
        bus.memwrite = 1'b0;
        check("write_word5");
        bus.addr = 40'd1;
        check("word1_untouched");

        drive(40'd5, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("memwrite_low_hold");
        end

        drive(40'd256, 32'd9, 1'b1);
        tick();
        check("oor_256_reads_zero");
        bus.memwrite = 1'b0;
        bus.addr = 40'd0;
        check("oor_word0");
        bus.addr = 40'd255;
        check("oor_word255");
        drive(40'h1_0000_0001, 32'h55, 1'b1);
        tick();
        check("oor_high_reads_zero");
        drive(40'h0_8000_0001, 32'h66, 1'b1);
        tick();
        bus.memwrite = 1'b0;
        check("oor_mid_reads_zero");
        bus.addr = 40'd1;
        check("no_alias_word1");
        bus.addr = 40'h101;
        check("no_alias_0x101");

        drive(40'd10, 32'hA5A5_0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_write");
        end
        for (int i = 20; i < 26; i++) begin
            drive(c_AW'(i), c_DW'(i * 17), 1'b1);
            tick();
            check("addr_walk_write");
        end
        bus.memwrite = 1'b0;
        for (int i = 20; i < 26; i++) begin
            bus.addr = c_AW'(i);
            check("addr_walk_read");
        end

        // Randomized phase with occasional reset and out-of-range traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:       a = c_AW'(c_DEPTH + $urandom_range(0, 4000));
                1:       a = {8'($urandom), 32'($urandom)};
                default: a = c_AW'($urandom_range(0, 255));
            endcase
            drive(a, 32'($urandom), ($urandom_range(0, 2) != 0));
            rst = ($urandom_range(0, 59) == 0);
            check("rand_pre_edge");
            tick();
            check("rand_post_edge");
            rst = 1'b0;
            bus.memwrite = 1'b0;
            bus.addr = c_AW'($urandom_range(0, 300));
            check("rand_read");
        end

        drive(40'd5, 32'd3, 1'b1);
        tick();
        drive(40'd1, 32'hFF, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.memwrite = 1'b0;
        check("rst_beats_write_word1");
        bus.addr = 40'd5;
        check("rst_clears_word5");
        drive(40'd1, 32'hFF, 1'b1);
        tick();
        bus.memwrite = 1'b0;
        check("write_after_reset");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_data_memory
`default_nettype wire
